// File: rtl/multi_channel_splitter.sv
// Splits a dibit-serial frame (channel ID, start address, payload) into per-channel
// byte strobes with auto-incremented addresses, and flags clean or broken frame ends.
module multi_channel_splitter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_BYTES = 3,
  parameter int ADDR_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [1:0]        axiid,
  input  logic              kill,
  output logic              addr_axiov,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        ch,
  output logic [NUM_CH-1:0] data_axiov,
  output logic [7:0]        data,
  output logic [ADDR_W-1:0] data_addr,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int BCW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

  typedef enum logic [2:0] {
    WAIT_GAP, IDLE, HDR_CH, HDR_ADDR, PAYLOAD, DROP
  } state_t;

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [5:0]        r_prev;
  logic [BCW-1:0]    r_bcnt;
  logic [ADDR_W-1:0] r_addr_sh;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [3:0]        r_ch;

  logic              w_byte_done;
  logic [7:0]        w_byte;
  logic [ADDR_W-1:0] w_addr_next;
  logic [NUM_CH-1:0] w_ch_sel;

  assign w_byte_done = axiiv && (r_cnt == 2'd3);
  assign w_byte      = {r_prev, axiid};
  assign w_addr_next = ADDR_W'({r_addr_sh, w_byte});
  assign ch          = r_ch;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
    assign w_ch_sel[gi] = (r_ch == 4'(gi));
  end

  // Dibit assembly runs in every state; the FSM only looks at it when a byte completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_prev <= '0;
    end else if (!axiiv) begin
      r_cnt <= '0;
    end else begin
      r_cnt  <= r_cnt + 2'd1;
      r_prev <= {r_prev[3:0], axiid};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= WAIT_GAP;
      r_bcnt     <= '0;
      r_addr_sh  <= '0;
      r_cur_addr <= '0;
      r_ch       <= '0;
      addr_axiov <= 1'b0;
      addr       <= '0;
      data_axiov <= '0;
      data       <= '0;
      data_addr  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      addr_axiov <= 1'b0;
      data_axiov <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        WAIT_GAP: begin
          if (!axiiv) r_state <= IDLE;
        end
        IDLE: begin
          if (axiiv) begin
            r_state <= HDR_CH;
            r_bcnt  <= '0;
          end
        end
        HDR_CH, HDR_ADDR, PAYLOAD, DROP: begin
          if (!axiiv) begin
            // A fall coinciding with kill still counts as a killed frame.
            r_state <= IDLE;
            if (r_state == PAYLOAD && r_cnt == 2'd0 && !kill) frame_done <= 1'b1;
            else                                              frame_err  <= 1'b1;
          end else if (kill) begin
            r_state <= DROP;
          end else if (w_byte_done) begin
            case (r_state)
              HDR_CH: begin
                r_ch    <= w_byte[3:0];
                r_bcnt  <= '0;
                r_state <= (w_byte < NUM_CH_B) ? HDR_ADDR : DROP;
              end
              HDR_ADDR: begin
                r_addr_sh <= w_addr_next;
                r_bcnt    <= r_bcnt + BCW'(1);
                if (r_bcnt == BCW'(ADDR_BYTES - 1)) begin
                  addr_axiov <= 1'b1;
                  addr       <= w_addr_next;
                  data_addr  <= w_addr_next;
                  r_cur_addr <= w_addr_next;
                  r_state    <= PAYLOAD;
                end
              end
              PAYLOAD: begin
                data       <= w_byte;
                data_axiov <= w_ch_sel;
                data_addr  <= r_cur_addr;
                r_cur_addr <= r_cur_addr + ADDR_W'(1);
              end
              default: ;
            endcase
          end
        end
        default: r_state <= WAIT_GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_channel_splitter.sv
// Drives two splitters (2 and 4 channels) with the same frames and checks every cycle
// against a frame-level model: byte b completes on dibit 4b+3 and shows up one cycle later.
module tb_multi_channel_splitter;

  typedef struct packed {
    logic        chk_all;
    logic        addr_v;
    logic [23:0] addr;
    logic [3:0]  ch;
    logic [15:0] dv;
    logic [7:0]  data;
    logic [23:0] da;
    logic        done;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [15:0] dv;
    logic [7:0]  data;
    logic [23:0] da;
  } strb_t;

  logic clk = 1'b0;
  logic rst, axiiv, kill;
  logic [1:0] axiid;

  logic        av2, fd2, fe2, av4, fd4, fe4;
  logic [23:0] ad2, da2, ad4, da4;
  logic [3:0]  ch2, ch4;
  logic [1:0]  dv2;
  logic [3:0]  dv4;
  logic [7:0]  dt2, dt4;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t  q0[$], q1[$];
  strb_t strb_q0[$], strb_q1[$];
  logic [23:0] m_da [2];
  logic [23:0] last_addr [2];
  int n_addr [2];
  int n_done [2];
  int n_err  [2];

  always #5 clk = ~clk;

  multi_channel_splitter #(.NUM_CH(2), .ADDR_BYTES(3), .ADDR_W(24)) u_dut2 (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .kill(kill),
    .addr_axiov(av2), .addr(ad2), .ch(ch2), .data_axiov(dv2), .data(dt2),
    .data_addr(da2), .frame_done(fd2), .frame_err(fe2)
  );

  multi_channel_splitter #(.NUM_CH(4), .ADDR_BYTES(3), .ADDR_W(24)) u_dut4 (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .kill(kill),
    .addr_axiov(av4), .addr(ad4), .ch(ch4), .data_axiov(dv4), .data(dt4),
    .data_addr(da4), .frame_done(fd4), .frame_err(fe4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs for cycle d of a frame (d<nd: dibit, d==nd: fall, d>nd: gap).
  function automatic exp_t model_cyc(input int di, input logic [7:0] fb[$], input int nd,
                                     input int d, input int kill_at, input int rst_at);
    exp_t e;
    int nch, b;
    logic bad, killed;
    logic [23:0] a;
    e = '0;
    nch = (di == 0) ? 2 : 4;
    bad = (nd >= 4) && (int'(fb[0]) >= nch);
    killed = (kill_at >= 1) && (d >= kill_at);
    a = {fb[1], fb[2], fb[3]};
    if (rst_at >= 0 && d >= rst_at) begin
      if (d == rst_at) begin
        e.chk_all = 1'b1;
        m_da[di] = '0;
      end
    end else if (d < nd) begin
      if (d % 4 == 3 && !killed && !bad) begin
        b = d / 4;
        if (b == 3) begin
          e.addr_v = 1'b1;
          e.addr = a;
          e.ch = fb[0][3:0];
          m_da[di] = a;
        end else if (b >= 4) begin
          e.dv = 16'd1 << fb[0][3:0];
          e.data = fb[b];
          e.ch = fb[0][3:0];
          m_da[di] = a + 24'(b - 4);
        end
      end
    end else if (d == nd) begin
      if (!killed && !bad && nd >= 16 && nd % 4 == 0) e.done = 1'b1;
      else e.err = 1'b1;
    end
    e.da = m_da[di];
    return e;
  endfunction

  task automatic cmp(input int di, input exp_t e, input logic av, input logic [23:0] ad,
                     input logic [3:0] c, input logic [15:0] dv, input logic [7:0] dt,
                     input logic [23:0] da, input logic fd, input logic fe);
    string p;
    strb_t s;
    p = (di == 0) ? "n2" : "n4";
    chk({p, ".addr_axiov"}, 32'(av), 32'(e.addr_v));
    chk({p, ".data_axiov"}, 32'(dv), 32'(e.dv));
    chk({p, ".data_addr"}, 32'(da), 32'(e.da));
    chk({p, ".frame_done"}, 32'(fd), 32'(e.done));
    chk({p, ".frame_err"}, 32'(fe), 32'(e.err));
    if (e.chk_all || e.addr_v) chk({p, ".addr"}, 32'(ad), 32'(e.addr));
    if (e.chk_all || e.addr_v || e.dv != 16'd0) chk({p, ".ch"}, 32'(c), 32'(e.ch));
    if (e.chk_all || e.dv != 16'd0) chk({p, ".data"}, 32'(dt), 32'(e.data));
    if (av === 1'b1) begin
      n_addr[di]++;
      last_addr[di] = ad;
    end
    if (dv != 16'd0) begin
      s.dv = dv; s.data = dt; s.da = da;
      if (di == 0) strb_q0.push_back(s);
      else strb_q1.push_back(s);
    end
    if (fd === 1'b1) n_done[di]++;
    if (fe === 1'b1) n_err[di]++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp(0, e, av2, ad2, ch2, {14'd0, dv2}, dt2, da2, fd2, fe2);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp(1, e, av4, ad4, ch4, {12'd0, dv4}, dt4, da4, fd4, fe4);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    strb_q0.delete();
    strb_q1.delete();
    for (int i = 0; i < 2; i++) begin
      n_addr[i] = 0; n_done[i] = 0; n_err[i] = 0;
    end
  endtask

  task automatic run_frame(input logic [7:0] fb[$], input int nd, input int kill_at,
                           input int rst_at, input int gap);
    logic [7:0] byt;
    $display("frame id=%02h addr=%02h%02h%02h dibits=%0d kill_at=%0d rst_at=%0d",
             fb[0], fb[1], fb[2], fb[3], nd, kill_at, rst_at);
    for (int d = 0; d <= nd + gap; d++) begin
      if (d < nd) begin
        byt   = fb[d / 4];
        axiiv = 1'b1;
        axiid = byt[7 - 2 * (d % 4) -: 2];
        rst   = (d == rst_at);
        kill  = (d == kill_at) || (rst_at >= 0 && d > rst_at && $urandom_range(0, 7) == 0);
      end else begin
        axiiv = 1'b0;
        axiid = 2'($urandom);
        rst   = 1'b0;
        kill  = (d == nd) ? (kill_at == nd) : ($urandom_range(0, 3) == 0);
      end
      q0.push_back(model_cyc(0, fb, nd, d, kill_at, rst_at));
      q1.push_back(model_cyc(1, fb, nd, d, kill_at, rst_at));
      step();
    end
  endtask

  initial begin
    logic [7:0] fb[$];
    logic [7:0] t1b [4];
    logic [23:0] t3a [3];
    exp_t e;
    int id, npay, nd, ka, gap;
    logic [23:0] a;

    rst = 1'b1; axiiv = 1'b0; axiid = 2'd0; kill = 1'b0;
    m_da[0] = '0; m_da[1] = '0;
    clr();
    for (int i = 0; i < 5; i++) begin
      e = '0;
      e.chk_all = (i < 3);
      rst = (i < 3);
      q0.push_back(e);
      q1.push_back(e);
      step();
    end

    // Channel 1 frame
    clr();
    fb = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h1B, 8'hC0, 8'h1B, 8'h1B};
    run_frame(fb, 32, -1, -1, 1);
    t1b = '{8'h1B, 8'hC0, 8'h1B, 8'h1B};
    chk("t1.n_addr", n_addr[0], 1);
    chk("t1.addr", last_addr[0], 24'h000100);
    chk("t1.n_strb", strb_q0.size(), 4);
    for (int i = 0; i < strb_q0.size() && i < 4; i++) begin
      chk("t1.dv", strb_q0[i].dv, 16'h0002);
      chk("t1.da", strb_q0[i].da, 24'h000100 + 24'(i));
      chk("t1.data", strb_q0[i].data, t1b[i]);
    end
    chk("t1.done", n_done[0], 1);

    // Bad channel
    clr();
    fb = '{8'h05, 8'h00, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    run_frame(fb, 28, -1, -1, 1);
    chk("t2.n_addr", n_addr[0], 0);
    chk("t2.n_strb", strb_q0.size(), 0);
    chk("t2.err", n_err[0], 1);
    chk("t2.done", n_done[0], 0);

    // Address wrap
    clr();
    fb = '{8'h00, 8'hFF, 8'hFF, 8'hFE, 8'h11, 8'h22, 8'h33};
    run_frame(fb, 28, -1, -1, 1);
    t3a = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};
    chk("t3.n_strb", strb_q0.size(), 3);
    for (int i = 0; i < strb_q0.size() && i < 3; i++) begin
      chk("t3.da", strb_q0[i].da, t3a[i]);
      chk("t3.dv", strb_q0[i].dv, 16'h0001);
    end

    // Truncated payload byte
    clr();
    fb = '{8'h01, 8'h12, 8'h34, 8'h56, 8'hA1, 8'hA2, 8'hA3};
    run_frame(fb, 26, -1, -1, 1);
    chk("t4.n_strb", strb_q0.size(), 2);
    chk("t4.err", n_err[0], 1);
    chk("t4.done", n_done[0], 0);

    // Kill on the completing dibit of the 3rd payload byte, then a clean frame
    clr();
    fb = '{8'h01, 8'h00, 8'h00, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(fb, 32, 27, -1, 1);
    chk("t5.n_strb", strb_q0.size(), 2);
    chk("t5.err", n_err[0], 1);
    clr();
    run_frame(fb, 32, -1, -1, 1);
    chk("t5.clean_done", n_done[0], 1);
    chk("t5.clean_strb", strb_q0.size(), 4);

    // Reset mid-payload with 59 more dibits, then a clean frame
    fb = '{8'h01, 8'h00, 8'h00, 8'h40};
    for (int i = 0; i < 16; i++) fb.push_back(8'($urandom));
    run_frame(fb, 80, -1, 21, 1);
    clr();
    fb = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h5A, 8'hA5};
    run_frame(fb, 24, -1, -1, 1);
    chk("t6.done", n_done[0], 1);
    chk("t6.n_strb", strb_q0.size(), 2);

    // Four back-to-back frames, IDs 0..3, one idle cycle apart
    clr();
    for (int i = 0; i < 4; i++) begin
      fb = '{8'(i), 8'h00, 8'h01, 8'h00, 8'(8'h30 + i)};
      run_frame(fb, 20, -1, -1, 0);
    end
    chk("t7.done4", n_done[1], 4);
    chk("t7.n_strb4", strb_q1.size(), 4);
    for (int i = 0; i < strb_q1.size() && i < 4; i++)
      chk("t7.dv4", strb_q1[i].dv, 16'd1 << i);
    chk("t7.done2", n_done[0], 2);
    chk("t7.err2", n_err[0], 2);

    // Random frames: IDs incl. bad ones, truncations, kills, near-wrap addresses
    for (int n = 0; n < 150; n++) begin
      id   = $urandom_range(0, 5);
      a    = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 3)) : 24'($urandom);
      npay = $urandom_range(0, 6);
      fb = '{8'(id), a[23:16], a[15:8], a[7:0]};
      for (int i = 0; i <= npay; i++) fb.push_back(8'($urandom));
      nd = 4 * (4 + npay);
      if ($urandom_range(0, 5) == 0) nd = $urandom_range(1, nd + 3);
      ka = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nd)) : -1;
      gap = $urandom_range(0, 2);
      run_frame(fb, nd, ka, -1, gap);
    end

    step();
    step();
    chk("q0.drained", q0.size(), 0);
    chk("q1.drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
